dm_arbiter: RTL and testbench

- Arbiter and sequencer for the shared 8-bit x 16-word data memory.
- Shares one single-port memory between two requesters: the micro's computational unit (CPU port) and an external debug/loader port (DBG port).
- The CPU has default priority. A starvation counter guarantees the DBG port forward progress.
- Sits between the micro's data-memory signals (address i, {r, data_bus}, write enable, q) and the memory macro.

---
 rtl/dm_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_dm_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Arbiter/sequencer sharing one single-port 16 x 8 data memory between the
// micro's computational unit (CPU port) and an external debug/loader port
// (DBG port). The CPU has default priority. A starvation counter forces a
// pending DBG access through after it has lost STARVE_LIMIT cycles to the CPU.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, a 1-bit round-robin pointer decides
//                        contended cycles instead of the starvation counter.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   cpu_req    CPU access request (held while stalled)
//   cpu_we     CPU access is a write
//   cpu_addr   CPU address
//   cpu_wdata  CPU write data
//   cpu_stall  CPU request not granted this cycle
//   cpu_rdata  CPU read data (mem_q passthrough, valid the cycle after grant)
//   dbg_req    DBG request level, held until dbg_ack
//   dbg_we     DBG access is a write
//   dbg_addr   DBG address
//   dbg_wdata  DBG write data
//   dbg_ack    one-cycle DBG completion pulse
//   dbg_rdata  registered DBG read data, captured at the end of the ack cycle
//   mem_addr   memory address
//   mem_data   memory write data
//   mem_wren   memory write enable
//   mem_q      memory read data (one clock after the address)
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_RESP = 2'd2
  } dbg_state_t;

  dbg_state_t state;
  dbg_state_t next_state;
  logic       in_wait;
  logic       dbg_win;
  logic       cpu_win;
  logic       win_we;

  assign in_wait = (state == D_WAIT);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // Grant: a lone requester wins; contended cycles go to the port rr_ptr names.
  always_comb begin
    if (in_wait) begin
      dbg_win = !cpu_req || rr_ptr;
    end else begin
      dbg_win = 1'b0;
    end
  end

  // Round-robin pointer flips after every contended grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (in_wait && cpu_req) begin
      rr_ptr <= ~rr_ptr;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  // Grant: DBG wins when the CPU is idle or DBG has lost LIMIT cycles already.
  always_comb begin
    if (in_wait) begin
      dbg_win = !cpu_req || (starve_cnt == LIMIT);
    end else begin
      dbg_win = 1'b0;
    end
  end

  // Starvation counter: counts cycles a waiting DBG access loses to the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (dbg_win) begin
      starve_cnt <= 4'd0;
    end else if (in_wait && cpu_win && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end
`endif

  assign cpu_win   = cpu_req && !dbg_win;
  assign cpu_stall = cpu_req && dbg_win;
  assign cpu_rdata = mem_q;

  // DBG FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= D_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DBG FSM next-state logic; dbg_req is ignored while responding.
  always_comb begin
    next_state = state;
    case (state)
      D_IDLE: begin
        if (dbg_req) begin
          next_state = D_WAIT;
        end else begin
          next_state = D_IDLE;
        end
      end
      D_WAIT: begin
        if (dbg_win) begin
          next_state = D_RESP;
        end else begin
          next_state = D_WAIT;
        end
      end
      D_RESP:  next_state = D_IDLE;
      default: next_state = D_IDLE;
    endcase
  end

  // DBG FSM outputs: the ack is decoded straight from the state register.
  always_comb begin
    case (state)
      D_RESP:  dbg_ack = 1'b1;
      default: dbg_ack = 1'b0;
    endcase
  end

  // Memory command mux; with no winner the CPU fields are presented, write off.
  always_comb begin
    mem_addr = cpu_addr;
    mem_data = cpu_wdata;
    win_we   = 1'b0;
    if (dbg_win) begin
      mem_addr = dbg_addr;
      mem_data = dbg_wdata;
      win_we   = dbg_we;
    end else if (cpu_win) begin
      mem_addr = cpu_addr;
      mem_data = cpu_wdata;
      win_we   = cpu_we;
    end else begin
      win_we   = 1'b0;
    end
  end

  // Write enable is gated by reset so no write can slip out while it is low.
  assign mem_wren = win_we & reset;

  // DBG read data is captured at the edge ending the response cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_rdata <= {DATA_W{1'b0}};
    end else if (state == D_RESP) begin
      dbg_rdata <= mem_q;
    end else begin
      dbg_rdata <= dbg_rdata;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
`timescale 1ns/1ps
module tb_dm_arbiter;
  localparam int LIMIT = 4;

  logic       clk;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_stall;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we, dbg_ack;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic [3:0] mem_addr;
  logic [7:0] mem_data, mem_q;
  logic       mem_wren;
  logic       mem_clear;
  logic [7:0] ram [16];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: transaction-level view of the arbiter plus a shadow memory.
  int shadow [16];
  int m_phase;      // 0 no DBG txn, 1 DBG waiting, 2 DBG responding
  int m_losses;     // cycles the waiting DBG txn has lost to the CPU
  int m_rr;         // port that wins the next contended cycle (0 CPU, 1 DBG)
  bit cpu_rd_pend;
  int cpu_rd_val;
  bit g_dbg_read;
  int g_dbg_val;
  bit dbg_rd_known;
  int dbg_rd_val;
  bit e_stall, e_ack;
  bit obs_stall, obs_ack;

  dm_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port read-first memory macro, registered output.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      mem_q <= 8'h00;
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      mem_q <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    m_phase = 0; m_losses = 0; m_rr = 0;
    cpu_rd_pend = 1'b0; dbg_rd_known = 1'b1; dbg_rd_val = 0;
    e_stall = 1'b0; e_ack = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, return after the rising edge.
  task automatic cycle();
    bit dw, cw, ew;
    int wa, wd;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    dw = (m_phase == 1) && (!cpu_req || m_rr == 1);
`else
    dw = (m_phase == 1) && (!cpu_req || m_losses == LIMIT);
`endif
    cw = cpu_req && !dw;
    ew = dw ? dbg_we : (cw ? cpu_we : 1'b0);
    wa = dw ? int'(dbg_addr) : int'(cpu_addr);
    wd = dw ? int'(dbg_wdata) : int'(cpu_wdata);
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && dw));
    check("dbg_ack", 32'(dbg_ack), 32'(m_phase == 2));
    check("mem_wren", 32'(mem_wren), 32'(ew));
    check("mem_addr", 32'(mem_addr), 32'(wa));
    check("mem_data", 32'(mem_data), 32'(wd));
    if (cpu_rd_pend) check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_rd_val));
    if (dbg_rd_known) check("dbg_rdata", 32'(dbg_rdata), 32'(dbg_rd_val));
    obs_stall = cpu_stall;
    obs_ack   = dbg_ack;
    e_stall   = cpu_req && dw;
    e_ack     = (m_phase == 2);
    if (m_phase == 2) begin
      dbg_rd_known = g_dbg_read;
      dbg_rd_val   = g_dbg_val;
    end
    if (dw) begin
      g_dbg_read = !dbg_we;
      g_dbg_val  = shadow[dbg_addr];
    end
    cpu_rd_pend = cw && !cpu_we;
    cpu_rd_val  = shadow[cpu_addr];
    if (ew) shadow[wa] = wd;
`ifdef ARB_ROUND_ROBIN_EN
    if (cpu_req && m_phase == 1) m_rr = 1 - m_rr;
`else
    if (dw) m_losses = 0;
    else if (m_phase == 1 && cw && m_losses < LIMIT) m_losses++;
`endif
    case (m_phase)
      0:       if (dbg_req) m_phase = 1;
      1:       if (dw) m_phase = 2;
      default: m_phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_txn(input logic we, input logic [3:0] a, input logic [7:0] d, output int lat);
    int n;
    n = 0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    do begin
      cycle();
      n++;
    end while (!obs_ack && n < 40);
    if (!obs_ack) check("dbg_ack_timeout", 32'(obs_ack), 32'd1);
    dbg_req = 1'b0;
    lat = n - 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int lat, first_stall, ack_at, n_stall;
    for (int i = 0; i < 16; i++) shadow[i] = 0;
    reset_model();
    g_dbg_read = 1'b0; g_dbg_val = 0; cpu_rd_val = 0;
    reset = 1'b0; mem_clear = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'hA5;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 4'd0; dbg_wdata = 8'h00;

    // Reset held with a CPU write request: nothing may reach the memory.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_rdata", 32'(dbg_rdata), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    mem_clear = 1'b0; cpu_req = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'hA5;
    cycle();
    cpu_we = 1'b0;
    cycle();
    check("rst_rd3", 32'(cpu_rdata), 32'hA5);
    cpu_req = 1'b0;

    // DBG with the CPU idle: grant next cycle, ack one later.
    dbg_txn(1'b1, 4'd7, 8'h3C, lat);
    check("dbg_wr_lat", 32'(lat), 32'd2);
    dbg_txn(1'b0, 4'd7, 8'h00, lat);
    check("dbg_rd_lat", 32'(lat), 32'd2);
    check("dbg_rd7", 32'(dbg_rdata), 32'h3C);

    // CPU requests every cycle while a DBG read waits.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd7;
    first_stall = 0; ack_at = 0; n_stall = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (obs_stall) begin
        n_stall++;
        if (first_stall == 0) first_stall = i;
      end
      if (obs_ack && ack_at == 0) begin
        ack_at = i;
        dbg_req = 1'b0;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    check("contend_first_stall", 32'(first_stall), 32'd3);
    check("contend_ack", 32'(ack_at), 32'd4);
`else
    check("starve_first_stall", 32'(first_stall), 32'(LIMIT + 2));
    check("starve_ack", 32'(ack_at), 32'(LIMIT + 3));
`endif
    check("starve_n_stall", 32'(n_stall), 32'd1);
    cpu_req = 1'b0;

`ifndef ARB_ROUND_ROBIN_EN
    // Same-address collision with DBG at its starvation limit.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd9; dbg_wdata = 8'h22;
    for (int i = 1; i <= LIMIT + 1; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'(i); cpu_wdata = 8'(i);
      cycle();
    end
    cpu_addr = 4'd9; cpu_wdata = 8'h11;
    cycle();
    check("coll_stall", 32'(obs_stall), 32'd1);
    cycle();
    check("coll_ack", 32'(obs_ack), 32'd1);
    dbg_req = 1'b0;
    cpu_we = 1'b0;
    cycle();
    check("coll_rd9", 32'(cpu_rdata), 32'h11);
    cpu_req = 1'b0;
`endif

    // Reset asserted in the middle of the response cycle.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd7;
    cycle();
    cycle();
    dbg_req = 1'b0;
    check("mid_pre_ack", 32'(dbg_ack), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_ack", 32'(dbg_ack), 32'd0);
    check("mid_rdata", 32'(dbg_rdata), 32'd0);
    check("mid_wren", 32'(mem_wren), 32'd0);
    reset_model();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    check("mid_post_rdata", 32'(dbg_rdata), 32'd0);
    dbg_txn(1'b0, 4'd7, 8'h00, lat);
    check("mid_post_lat", 32'(lat), 32'd2);
    check("mid_post_rd7", 32'(dbg_rdata), 32'h3C);

    // Randomized traffic; masters hold their requests until served.
    for (int i = 0; i < 3000; i++) begin
      if (!(cpu_req && e_stall)) begin
        cpu_req   = ($urandom_range(0, 99) < 65);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 4'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      if (!(dbg_req && !e_ack)) begin
        dbg_req   = ($urandom_range(0, 99) < 35);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 4'($urandom_range(0, 15));
        dbg_wdata = 8'($urandom_range(0, 255));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
